circuit_evaluator: RTL and testbench
====================================

Name: circuit_evaluator

Overview:
Fitness-evaluation sequencer for the evolved logic-element array. After a chromosome has been loaded into the array's configuration registers, it sweeps every primary-input vector through the combinational circuit and waits a programmable settle time on each one. It then samples the circuit outputs and compares them against a target truth table held in an external ROM. It reports the number of matching output bits as the fitness score to the genetic-algorithm controller.

Parameters:
N_IN, 5, number of primary circuit inputs; vectors 0 .. 2^N_IN-1 are swept
N_OUT, 2, number of circuit outputs compared per vector
SETTLE, 4, cycles each vector is held before sampling; legal range 1..255
FIT_W, 7, fitness width; must satisfy 2^FIT_W > N_OUT*2^N_IN (default max 64)

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin an evaluation run; sampled only in IDLE
abort  in  1  cancel the run in progress; no done, fitness unchanged
busy  out  1  high in APPLY and SAMPLE
done  out  1  one-cycle pulse when fitness is updated
circ_in  out  N_IN  primary-input vector driven into the logic-element array
circ_out  in  N_OUT  circuit outputs from the array
exp_addr  out  N_IN  target-ROM address; always equals circ_in
exp_data  in  N_OUT  expected outputs; valid 1 cycle after exp_addr changes
fitness  out  FIT_W  matching-bit count of the last completed run

Behaviour:
- Reset is asynchronous and active-high on rst, with a single clock clk. While rst is high:
  - state=IDLE;
  - vec, settle counter, accumulator, fitness, busy and done all 0.
- Outputs: circ_in = exp_addr = vec register. busy and done are decoded from state and registered.
- IDLE:
  - start=1 → clear vec and accumulator, load the settle counter with SETTLE-1, go to APPLY.
  - Otherwise hold.
- APPLY:
  - Lasts exactly SETTLE cycles; the counter decrements each cycle.
  - When the counter is 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - acc += popcount(~(circ_out ^ exp_data)), computed at accumulator width. No saturation is needed, guaranteed by the FIT_W rule.
  - If vec == 2^N_IN-1 → DONE.
  - Otherwise vec += 1, reload the counter with SETTLE-1, go to APPLY.
- DONE (1 cycle):
  - done=1, fitness is loaded with acc on entry, vec cleared.
  - Next state is IDLE.
  - fitness then holds until the next completed run.
- Timing: with start high in cycle 0, vector k is in APPLY for cycles k*(SETTLE+1)+1 .. k*(SETTLE+1)+SETTLE. Its SAMPLE is cycle (k+1)*(SETTLE+1). done is high in cycle 2^N_IN*(SETTLE+1)+1.
- Boundaries:
  - start while busy or in DONE is ignored.
  - start held high continuously begins a new run in the cycle after DONE.
  - abort in APPLY or SAMPLE → IDLE next cycle, vec cleared, no accumulation in that cycle, no done, fitness unchanged.
  - abort takes priority over SAMPLE completion.
  - abort in IDLE or DONE has no effect.
  - Simultaneous start and abort in IDLE: start wins.
  - rst asserted mid-run clears everything immediately, including fitness.
  - SETTLE=1: APPLY lasts a single cycle. The exp_data 1-cycle latency is still met because exp_addr changes on entry to APPLY.
  - vec never wraps; the terminal vector is detected by compare, not by overflow.

Test Plan:
- Params N_IN=2, N_OUT=1, SETTLE=2; circ_out = AND(circ_in), ROM = AND; start pulse in cycle 0 → busy high cycles 1..12, done only in cycle 13, fitness=4.
- Same params, circ_out=AND, ROM=XOR → matches only at vector 0; fitness=1; circ_in sequence 0,1,2,3, each held 3 cycles.
- Defaults (N_IN=5, N_OUT=2, SETTLE=4), circ_out = ~exp_data on both bits → fitness=0; circ_out = exp_data → fitness=64 (no overflow, FIT_W=7); done in cycle 161.
- Complete a run with fitness=4, then start and assert abort at cycle 5 → busy low at cycle 6, circ_in=0, no done, fitness stays 4; start again → normal completion.
- start pulsed again at cycle 4 of a run, and start+abort together in IDLE → first pulse ignored, timing unchanged; combined pulse starts a run.
- rst asserted mid-APPLY, released 2 cycles later → all outputs 0 immediately on assertion, state IDLE, and the next start runs a full sweep from vector 0.

Source files
------------

// File: rtl/circuit_evaluator.sv
`default_nettype none
// ============================================================================
// circuit_evaluator: sweeps all input vectors through the evolved array, waits
// SETTLE cycles on each vector, then scores the outputs against a target ROM.
// Revision: 1.0
// ============================================================================
module circuit_evaluator #(
  parameter int N_IN   = 5,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 4,
  parameter int FIT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  circ_in,
  input  logic [N_OUT-1:0] circ_out,
  output logic [N_IN-1:0]  exp_addr,
  input  logic [N_OUT-1:0] exp_data,
  output logic [FIT_W-1:0] fitness
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [7:0]      CNT_LOAD = 8'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [FIT_W-1:0] acc_q, acc_d;
  logic [FIT_W-1:0] fitness_q, fitness_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N_OUT-1:0] match;
  logic [FIT_W-1:0] match_cnt;
  logic [FIT_W-1:0] acc_sum;

  always_comb begin
    match     = ~(circ_out ^ exp_data);
    match_cnt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      match_cnt = match_cnt + FIT_W'(match[i]);
    end
    acc_sum = acc_q + match_cnt;
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    fitness_d = fitness_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (abort) begin
          vec_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        // abort outranks both accumulation and completion
        if (abort) begin
          vec_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
          if (vec_q == VEC_LAST) begin
            fitness_d = acc_sum;
            vec_d     = '0;
            state_d   = S_DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
            state_d = S_APPLY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_APPLY) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      fitness_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      fitness_q <= fitness_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign circ_in  = vec_q;
  assign exp_addr = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fitness  = fitness_q;

endmodule
`default_nettype wire

// File: tb/tb_circuit_evaluator.sv
`default_nettype none
// ============================================================================
// tb_circuit_evaluator: scoreboard bench for a small (2-in/1-out/SETTLE=2) and a
// default-parameter evaluator. Revision: 1.0
// ============================================================================
module tb_circuit_evaluator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- small instance ----------------
  logic       rst_s, start_s, abort_s, busy_s, done_s;
  logic [1:0] circ_in_s, exp_addr_s;
  logic [0:0] circ_out_s, exp_data_s;
  logic [2:0] fitness_s;
  int         rom_mode_s = 0;
  int         sb_s[$];

  function automatic logic f_s(input logic [1:0] v);
    return v[0] & v[1];
  endfunction

  function automatic logic rom_s(input logic [1:0] v, input int m);
    return (m == 0) ? (v[0] & v[1]) : (v[0] ^ v[1]);
  endfunction

  function automatic int model_s(input int m);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      if (f_s(2'(i)) == rom_s(2'(i), m)) s++;
    end
    return s;
  endfunction

  assign circ_out_s = f_s(circ_in_s);
  always @(posedge clk) exp_data_s <= rom_s(exp_addr_s, rom_mode_s);

  circuit_evaluator #(.N_IN(2), .N_OUT(1), .SETTLE(2), .FIT_W(3)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .abort(abort_s),
    .busy(busy_s), .done(done_s), .circ_in(circ_in_s), .circ_out(circ_out_s),
    .exp_addr(exp_addr_s), .exp_data(exp_data_s), .fitness(fitness_s)
  );

  // ---------------- default instance ----------------
  logic       rst_d, start_d, abort_d, busy_d, done_d;
  logic [4:0] circ_in_d, exp_addr_d;
  logic [1:0] circ_out_d, exp_data_d;
  logic [6:0] fitness_d;
  int         mode_d = 0;
  int         sb_d[$];

  function automatic logic [1:0] rom_d(input logic [4:0] v);
    return {v[4] ^ v[1], v[0] & v[3]};
  endfunction

  function automatic logic [1:0] func_d(input logic [4:0] v);
    return {v[0], v[1] | v[2]};
  endfunction

  function automatic int model_d(input int m);
    int s = 0;
    logic [1:0] e, o, mt;
    for (int i = 0; i < 32; i++) begin
      e  = rom_d(5'(i));
      o  = (m == 0) ? ~e : (m == 1) ? e : func_d(5'(i));
      mt = ~(o ^ e);
      s  = s + int'(mt[0]) + int'(mt[1]);
    end
    return s;
  endfunction

  assign circ_out_d = (mode_d == 0) ? ~exp_data_d :
                      (mode_d == 1) ? exp_data_d : func_d(circ_in_d);
  always @(posedge clk) exp_data_d <= rom_d(exp_addr_d);

  circuit_evaluator dut_d (
    .clk(clk), .rst(rst_d), .start(start_d), .abort(abort_d),
    .busy(busy_d), .done(done_d), .circ_in(circ_in_d), .circ_out(circ_out_d),
    .exp_addr(exp_addr_d), .exp_data(exp_data_d), .fitness(fitness_d)
  );

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (done_s) begin
      if (sb_s.size() == 0) chk("s_unexp_done", int'(done_s), 0);
      else chk("s_fitness", int'(fitness_s), sb_s.pop_front());
    end
    if (done_d) begin
      if (sb_d.size() == 0) chk("d_unexp_done", int'(done_d), 0);
      else chk("d_fitness", int'(fitness_d), sb_d.pop_front());
    end
  end

  // One small-instance run; start raised in cycle 0.
  task automatic run_s(input int rmode, input bit restart4, input bit abort0);
    rom_mode_s = rmode;
    sb_s.push_back(model_s(rmode));
    start_s = 1'b1;
    abort_s = abort0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start_s = (c == 4) && restart4;
      abort_s = 1'b0;
      chk("s_busy", int'(busy_s), int'(c >= 1 && c <= 12));
      chk("s_done", int'(done_s), int'(c == 13));
      if (c <= 12) chk("s_circ_in", int'(circ_in_s), (c - 1) / 3);
      if (c <= 12) chk("s_exp_addr", int'(exp_addr_s), (c - 1) / 3);
    end
    start_s = 1'b0;
  endtask

  task automatic run_d(input int m);
    int dc = -1;
    mode_d = m;
    sb_d.push_back(model_d(m));
    start_d = 1'b1;
    for (int c = 1; c <= 165; c++) begin
      tick();
      start_d = 1'b0;
      if (done_d && dc < 0) dc = c;
      if (c == 1 || c == 160 || c == 161)
        chk("d_busy", int'(busy_d), int'(c != 161));
    end
    chk("d_done_cycle", dc, 161);
  endtask

  initial begin
    rst_s = 1'b1; start_s = 1'b0; abort_s = 1'b0;
    rst_d = 1'b1; start_d = 1'b0; abort_d = 1'b0;
    tick(); tick();
    chk("rst_busy_s", int'(busy_s), 0);
    chk("rst_done_s", int'(done_s), 0);
    chk("rst_vec_s", int'(circ_in_s), 0);
    chk("rst_fit_s", int'(fitness_s), 0);
    chk("rst_busy_d", int'(busy_d), 0);
    chk("rst_fit_d", int'(fitness_d), 0);
    rst_s = 1'b0; rst_d = 1'b0;
    tick();

    // AND vs AND
    run_s(0, 1'b0, 1'b0);

    // abort in APPLY of vector 1: no done, fitness held
    start_s = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start_s = 1'b0;
      abort_s = (c == 5);
      if (c == 6) begin
        chk("ab_busy", int'(busy_s), 0);
        chk("ab_circ_in", int'(circ_in_s), 0);
        chk("ab_fitness", int'(fitness_s), model_s(0));
      end
      if (c >= 6) chk("ab_no_done", int'(done_s), 0);
    end
    abort_s = 1'b0;
    run_s(0, 1'b0, 1'b0);

    // AND vs XOR with an ignored start pulse mid-run
    run_s(1, 1'b1, 1'b0);
    // start+abort together in IDLE
    run_s(0, 1'b0, 1'b1);

    // start held high: back-to-back runs
    sb_s.push_back(model_s(0));
    sb_s.push_back(model_s(0));
    start_s = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 20) start_s = 1'b0;
      chk("hold_busy", int'(busy_s), int'((c >= 1 && c <= 12) || (c >= 15 && c <= 26)));
      chk("hold_done", int'(done_s), int'(c == 13 || c == 27));
      if (c == 15) chk("hold_vec0", int'(circ_in_s), 0);
    end

    // asynchronous reset mid-APPLY
    start_s = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_s = 1'b0;
    end
    rst_s = 1'b1;
    #1;
    chk("mrst_busy", int'(busy_s), 0);
    chk("mrst_done", int'(done_s), 0);
    chk("mrst_circ_in", int'(circ_in_s), 0);
    chk("mrst_fitness", int'(fitness_s), 0);
    tick(); tick();
    rst_s = 1'b0;
    run_s(1, 1'b0, 1'b0);

    // default parameters
    run_d(0);
    run_d(1);
    run_d(2);
    chk("d_fit_hold", int'(fitness_d), model_d(2));

    tick();
    chk("sb_s_empty", sb_s.size(), 0);
    chk("sb_d_empty", sb_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
